// File: rtl/cpu_run_controller.sv
// Gates the variable-clock tick stream into single-cycle CPU clock pulses.
// Supports run/pause, single-step, fixed-length burst and a PC breakpoint driven by debounced buttons.
module cpu_run_controller #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int BURST_LEN       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        btn_run,
   input  logic        btn_step,
   input  logic        btn_burst,
   input  logic        bp_enable,
   input  logic [31:0] bp_address,
   input  logic [31:0] pc,
   output logic        cpu_tick,
   output logic [1:0]  state,
   output logic        halted,
   output logic [15:0] tick_count
);

   localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0]   BURST_VAL = 16'(BURST_LEN);

   typedef enum logic [1:0] {
      ST_PAUSED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_BREAK  = 2'd3
   } state_t;

   logic [2:0] btn_raw;
   logic [2:0] press;

   assign btn_raw = {btn_burst, btn_step, btn_run};

   // Index 0 = run, 1 = step, 2 = burst.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         logic          sync0_reg;
         logic          sync1_reg;
         logic          level_reg;
         logic          press_reg;
         logic [CW-1:0] count_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync0_reg <= 1'b0;
               sync1_reg <= 1'b0;
               level_reg <= 1'b0;
               press_reg <= 1'b0;
               count_reg <= '0;
            end else begin
               sync0_reg <= btn_raw[gi];
               sync1_reg <= sync0_reg;
               press_reg <= 1'b0;
               if (sync1_reg == level_reg) begin
                  count_reg <= '0;
               end else if (count_reg == CNT_MAX) begin
                  level_reg <= sync1_reg;
                  count_reg <= '0;
                  press_reg <= sync1_reg;
               end else begin
                  count_reg <= count_reg + CW'(1);
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   state_t      state_reg, state_next;
   logic [15:0] remaining_reg, remaining_next;
   logic        bp_skip_reg, bp_skip_next;
   logic        cpu_tick_reg;
   logic [15:0] tick_count_reg;

   logic run_press, step_press, burst_press;
   logic issuing, bp_hit, accept, hit;

   always_comb begin
      run_press      = press[0];
      step_press     = press[1] & ~press[0];
      burst_press    = press[2] & ~press[1] & ~press[0];
      issuing        = (state_reg == ST_RUN) || (state_reg == ST_STEP);
      bp_hit         = bp_enable && (pc == bp_address) && !bp_skip_reg;
      accept         = tick_in && issuing && !bp_hit;
      hit            = tick_in && issuing && bp_hit;
      state_next     = state_reg;
      remaining_next = remaining_reg;
      bp_skip_next   = bp_skip_reg & ~accept;

      unique case (state_reg)
         ST_PAUSED, ST_BREAK: begin
            if (run_press) begin
               state_next = ST_RUN;
            end else if (step_press) begin
               state_next     = ST_STEP;
               remaining_next = 16'd1;
            end else if (burst_press) begin
               state_next     = ST_STEP;
               remaining_next = BURST_VAL;
            end
            // Leaving BREAK must let the instruction at the breakpoint execute once.
            if (state_reg == ST_BREAK && state_next != ST_BREAK) begin
               bp_skip_next = 1'b1;
            end
         end
         ST_RUN: begin
            if (hit) begin
               state_next     = ST_BREAK;
               remaining_next = 16'd0;
            end else if (run_press) begin
               state_next = ST_PAUSED;
            end
         end
         ST_STEP: begin
            if (hit) begin
               state_next     = ST_BREAK;
               remaining_next = 16'd0;
            end else if (run_press) begin
               state_next     = ST_PAUSED;
               remaining_next = 16'd0;
            end else if (accept) begin
               if (remaining_reg <= 16'd1) begin
                  state_next     = ST_PAUSED;
                  remaining_next = 16'd0;
               end else begin
                  remaining_next = remaining_reg - 16'd1;
               end
            end
         end
         default: state_next = ST_PAUSED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_PAUSED;
         remaining_reg  <= 16'd0;
         bp_skip_reg    <= 1'b0;
         cpu_tick_reg   <= 1'b0;
         tick_count_reg <= 16'd0;
      end else begin
         state_reg      <= state_next;
         remaining_reg  <= remaining_next;
         bp_skip_reg    <= bp_skip_next;
         cpu_tick_reg   <= accept;
         tick_count_reg <= tick_count_reg + {15'd0, accept};
      end
   end

   assign cpu_tick   = cpu_tick_reg;
   assign state      = state_reg;
   assign halted     = (state_reg == ST_PAUSED) || (state_reg == ST_BREAK);
   assign tick_count = tick_count_reg;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized-stimulus bench for cpu_run_controller: a behavioural model predicts every cpu_tick
// into a scoreboard queue, and a monitor pops and compares as the DUT produces ticks.
module tb_cpu_run_controller;
   localparam int DB = 4;
   localparam int BL = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_in = 1'b0;
   logic        btn_run = 1'b0, btn_step = 1'b0, btn_burst = 1'b0;
   logic        bp_enable = 1'b0;
   logic [31:0] bp_address = 32'h20;
   logic [31:0] pc = 32'd0;
   logic        cpu_tick;
   logic [1:0]  state;
   logic        halted;
   logic [15:0] tick_count;

   cpu_run_controller #(.DEBOUNCE_CYCLES(DB), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst), .tick_in(tick_in),
      .btn_run(btn_run), .btn_step(btn_step), .btn_burst(btn_burst),
      .bp_enable(bp_enable), .bp_address(bp_address), .pc(pc),
      .cpu_tick(cpu_tick), .state(state), .halted(halted), .tick_count(tick_count)
   );

   always #5 clk = ~clk;

   int asserts = 0;
   int fails = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      asserts++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Tick source: one pulse every tick_period clocks.
   int tick_period = 3;
   int tick_phase = 0;
   always @(negedge clk) begin
      if (tick_phase >= tick_period - 1) begin
         tick_phase = 0;
         tick_in = 1'b1;
      end else begin
         tick_phase++;
         tick_in = 1'b0;
      end
   end

   // Fetch address: advances one instruction per executed CPU tick.
   bit pc_clear = 1'b1;
   always @(negedge clk) begin
      if (pc_clear) pc = 32'd0;
      else if (cpu_tick) pc = pc + 32'd4;
   end

   // Reference model: 0=PAUSED 1=RUN 2=STEP 3=BREAK.
   typedef struct { int at_cyc; int cnt; } exp_t;
   exp_t sbq[$];
   int m_state = 0, m_rem = 0, m_count = 0;
   bit m_skip = 0;
   bit mp[3], ms0[3], ms1[3], mlev[3];
   int mrun[3];
   bit raw[3];
   bit r_p, s_p, b_p, going, hit_m, acc;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_state = 0; m_rem = 0; m_count = 0; m_skip = 0;
         for (int i = 0; i < 3; i++) begin
            mp[i] = 0; ms0[i] = 0; ms1[i] = 0; mlev[i] = 0; mrun[i] = 0;
         end
      end else begin
         r_p = mp[0];
         s_p = mp[1] && !r_p;
         b_p = mp[2] && !mp[1] && !r_p;
         going = (m_state == 1) || (m_state == 2);
         hit_m = tick_in && going && bp_enable && (pc == bp_address) && !m_skip;
         acc = tick_in && going && !hit_m;
         if (acc) begin
            m_count = (m_count + 1) % 65536;
            m_skip = 0;
            sbq.push_back('{cyc, m_count});
         end
         if (m_state == 0 || m_state == 3) begin
            if (r_p || s_p || b_p) begin
               if (m_state == 3) m_skip = 1;
               if (r_p) m_state = 1;
               else begin
                  m_state = 2;
                  m_rem = s_p ? 1 : BL;
               end
            end
         end else if (hit_m) begin
            m_state = 3; m_rem = 0;
         end else if (r_p) begin
            m_state = 0; m_rem = 0;
         end else if (m_state == 2 && acc) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_state = 0;
         end
         raw[0] = btn_run; raw[1] = btn_step; raw[2] = btn_burst;
         for (int i = 0; i < 3; i++) begin
            mp[i] = 0;
            if (ms1[i] != mlev[i]) begin
               mrun[i]++;
               if (mrun[i] == DB) begin
                  mlev[i] = ms1[i]; mrun[i] = 0; mp[i] = ms1[i];
               end
            end else mrun[i] = 0;
            ms1[i] = ms0[i];
            ms0[i] = raw[i];
         end
      end
   end

   // Monitor: pop one expectation per observed cpu_tick.
   exp_t mon_e;
   always @(negedge clk) begin
      if (check_en) begin
         if (cpu_tick) begin
            if (sbq.size() == 0) check("unexpected_tick", 1, 0);
            else begin
               mon_e = sbq.pop_front();
               check("tick_cycle", cyc, mon_e.at_cyc);
               check("tick_count_at_tick", tick_count, mon_e.cnt);
            end
         end
         check("state_vs_model", state, m_state);
         check("halted_vs_model", halted, (m_state == 0 || m_state == 3) ? 1 : 0);
      end
   end

   task automatic press(input int which, input int hold);
      @(negedge clk);
      case (which)
         0: btn_run = 1'b1;
         1: btn_step = 1'b1;
         2: btn_burst = 1'b1;
         default: begin btn_run = 1'b1; btn_step = 1'b1; end
      endcase
      repeat (hold) @(negedge clk);
      btn_run = 1'b0; btn_step = 1'b0; btn_burst = 1'b0;
   endtask

   task automatic wait_ticks(input int n, input int limit, input string name);
      int seen = 0;
      for (int i = 0; i < limit && seen < n; i++) begin
         @(negedge clk);
         if (cpu_tick) seen++;
      end
      check(name, seen, n);
   endtask

   int snap;
   int lim;

   initial begin
      repeat (2) @(negedge clk);
      check("reset_state", state, 0);
      check("reset_halted", halted, 1);
      check("reset_cpu_tick", cpu_tick, 0);
      check("reset_tick_count", tick_count, 0);
      rst = 1'b0;
      check_en = 1'b1;
      repeat (50) @(negedge clk);
      check("idle_ticks_ignored", tick_count, 0);
      $display("phase reset done, tick_count=%0d", tick_count);

      press(1, 2);
      repeat (30) @(negedge clk);
      check("glitch_no_step", tick_count, 0);
      check("glitch_state", state, 0);

      press(1, 8 + $urandom_range(0, 4));
      repeat (30) @(negedge clk);
      check("step_count", tick_count, 1);
      check("step_state", state, 0);
      $display("phase step done, tick_count=%0d", tick_count);

      press(2, 10);
      repeat (60) @(negedge clk);
      check("burst_count", tick_count, 6);
      check("burst_state", state, 0);
      $display("phase burst done, tick_count=%0d", tick_count);

      @(negedge clk);
      btn_burst = 1'b1;
      wait_ticks(2, 200, "burst_abort_first2");
      btn_burst = 1'b0;
      press(0, 10);
      repeat (30) @(negedge clk);
      check("burst_abort_state", state, 0);
      check("burst_abort_short", (tick_count > 7 && tick_count < 11) ? 1 : 0, 1);
      check("burst_abort_model", tick_count, m_count);
      $display("phase burst abort done, tick_count=%0d", tick_count);

      repeat ($urandom_range(0, 5)) @(negedge clk);
      press(0, 10);
      repeat (20 + $urandom_range(0, 20)) @(negedge clk);
      check("run_state", state, 1);
      press(0, 10);
      repeat (20) @(negedge clk);
      check("pause_state", state, 0);
      snap = m_count;
      repeat (30) @(negedge clk);
      check("pause_no_ticks", tick_count, snap);
      $display("phase run/pause done, tick_count=%0d", tick_count);

      pc_clear = 1'b0;
      bp_enable = 1'b1;
      snap = m_count;
      press(0, 10);
      lim = 0;
      while (state != 2'd3 && lim < 300) begin
         @(negedge clk);
         lim++;
      end
      check("bp_reached", state, 3);
      check("bp_halted", halted, 1);
      check("bp_ticks_before", tick_count, (snap + 8) % 65536);
      check("bp_pc", pc, 32'h20);
      press(0, 10);
      wait_ticks(1, 100, "bp_resume_tick");
      repeat (12) @(negedge clk);
      check("bp_resume_running", state, 1);
      check("bp_resume_pc_past", (pc > 32'h20) ? 1 : 0, 1);
      press(0, 10);
      repeat (20) @(negedge clk);
      bp_enable = 1'b0;
      check("bp_paused", state, 0);
      $display("phase breakpoint done, tick_count=%0d", tick_count);

      press(3, 10);
      repeat (10) @(negedge clk);
      check("simul_run_wins", state, 1);
      tick_period = 1;
      lim = 0;
      while (tick_count != 16'hFFFF && lim < 70000) begin
         @(negedge clk);
         lim++;
      end
      check("wrap_reached_ffff", tick_count, 16'hFFFF);
      @(negedge clk);
      check("wrap_to_zero", tick_count, 0);
      check("wrap_tick", cpu_tick, 1);
      press(0, 10);
      repeat (20) @(negedge clk);
      check("wrap_paused", state, 0);
      tick_period = 3;
      $display("phase wrap done, tick_count=%0d", tick_count);

      @(negedge clk);
      btn_burst = 1'b1;
      wait_ticks(1, 200, "rst_burst_first");
      btn_burst = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("rst_abort_count", tick_count, 0);
      check("rst_abort_state", state, 0);
      $display("phase reset-abort done, tick_count=%0d", tick_count);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
